// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared defaults and width helper for the switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int DEFAULT_THRESH   = 5;
    localparam int DEFAULT_PRESCALE = 1;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: 2-flop synchroniser, stability counter,
//               debounced level and one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int THRESH       = DEFAULT_THRESH,
    parameter int REL_DEBOUNCE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic evt_nxt
);

    localparam int            CW             = clog2_min1(THRESH);
    localparam logic [CW-1:0] c_cnt_last     = CW'(THRESH - 1);
    localparam bit            c_fast_release = (REL_DEBOUNCE == 0);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_out;
    logic          r_rise;
    logic          r_fall;

    logic [CW-1:0] w_cnt_nxt;
    logic          w_out_nxt;
    logic          w_rise_nxt;
    logic          w_fall_nxt;

    // Next-state decision, taken only on sample ticks; any agreeing sample
    // clears the count so interrupted glitches never add up.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_out_nxt  = r_out;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        if (tick) begin
            if (r_s2 == r_out) begin
                w_cnt_nxt = '0;
            end else if (c_fast_release && r_out && !r_s2) begin
                w_out_nxt  = 1'b0;
                w_fall_nxt = 1'b1;
                w_cnt_nxt  = '0;
            end else if (r_cnt == c_cnt_last) begin
                w_out_nxt  = r_s2;
                w_rise_nxt = r_s2;
                w_fall_nxt = ~r_s2;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= in;
            r_s2   <= r_s1;
            r_cnt  <= w_cnt_nxt;
            r_out  <= w_out_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
        end
    end

    assign out     = r_out;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign evt_nxt = w_rise_nxt | w_fall_nxt;

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : N-channel switch debouncer with shared sample-tick prescaler
//               and a combined any_change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int THRESH       = DEFAULT_THRESH,
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int REL_DEBOUNCE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_change
);

    localparam int            PW         = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] c_pre_last = PW'(PRESCALE - 1);

    logic [PW-1:0]   r_pre;
    logic            r_any_change;
    logic            w_tick;
    logic [N_CH-1:0] w_evt_nxt;

    // With PRESCALE=1 the counter stays at 0 and tick is permanently high.
    assign w_tick = (r_pre == c_pre_last);

    // Sample-tick prescaler, wrapping 0..PRESCALE-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .THRESH       (THRESH),
            .REL_DEBOUNCE (REL_DEBOUNCE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (w_tick),
            .in      (in[i]),
            .out     (out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .evt_nxt (w_evt_nxt[i])
        );
    end

    // Registered alongside the per-channel pulses so it aligns with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_evt_nxt;
        end
    end

    assign any_change = r_any_change;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Directed self-checking bench for debounce_multi: default
//               build, immediate-release build and a prescaled build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    logic       clk;
    logic       rst;
    logic [3:0] in_a, in_b, in_c;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;
    logic [3:0] out_c, rise_c, fall_c;
    logic       any_a, any_b, any_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel_cyc = 0;

    debounce_multi #(.N_CH(4), .THRESH(5), .PRESCALE(1), .REL_DEBOUNCE(1)) dut_a (
        .clk(clk), .rst(rst), .in(in_a), .out(out_a),
        .rise(rise_a), .fall(fall_a), .any_change(any_a)
    );

    debounce_multi #(.N_CH(4), .THRESH(5), .PRESCALE(1), .REL_DEBOUNCE(0)) dut_b (
        .clk(clk), .rst(rst), .in(in_b), .out(out_b),
        .rise(rise_b), .fall(fall_b), .any_change(any_b)
    );

    debounce_multi #(.N_CH(4), .THRESH(3), .PRESCALE(4), .REL_DEBOUNCE(1)) dut_c (
        .clk(clk), .rst(rst), .in(in_c), .out(out_c),
        .rise(rise_c), .fall(fall_c), .any_change(any_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst  = 1'b1;
        in_a = 4'b0;
        in_b = 4'b0;
        in_c = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_a, rise_a, fall_a, any_a} !== 13'b0) begin
            bad++;
            $display("FAIL reset_a: got %b want 0", {out_a, rise_a, fall_a, any_a});
        end
        total++;
        if ({out_b, rise_b, fall_b, any_b} !== 13'b0) begin
            bad++;
            $display("FAIL reset_b: got %b want 0", {out_b, rise_b, fall_b, any_b});
        end
        total++;
        if ({out_c, rise_c, fall_c, any_c} !== 13'b0) begin
            bad++;
            $display("FAIL reset_c: got %b want 0", {out_c, rise_c, fall_c, any_c});
        end
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    // Capture edge k is the edge after the drive; out changes at k+6.
    task automatic test_press();
        logic [3:0] exp_out, exp_rise;
        logic       exp_any;
        in_a = 4'b0001;
        for (int j = 0; j <= 8; j++) begin
            @(posedge clk);
            #1;
            exp_out  = (j >= 6) ? 4'b0001 : 4'b0000;
            exp_rise = (j == 6) ? 4'b0001 : 4'b0000;
            exp_any  = (j == 6);
            total++;
            if (out_a !== exp_out) begin
                bad++;
                $display("FAIL press_out j=%0d: got %b want %b", j, out_a, exp_out);
            end
            total++;
            if (rise_a !== exp_rise || any_a !== exp_any) begin
                bad++;
                $display("FAIL press_pulse j=%0d: rise %b any %b want %b %b",
                         j, rise_a, any_a, exp_rise, exp_any);
            end
        end
    endtask

    // Two runs of THRESH-1 high samples split by a single low sample.
    task automatic test_glitch();
        logic [9:0] pat;
        pat = 10'b0111101111;
        for (int i = 0; i < 18; i++) begin
            in_a[1] = (i < 10) ? pat[i] : 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (out_a[1] !== 1'b0 || rise_a !== 4'b0 || fall_a !== 4'b0) begin
                bad++;
                $display("FAIL glitch i=%0d: out1 %b rise %b fall %b want 0 0 0",
                         i, out_a[1], rise_a, fall_a);
            end
        end
    endtask

    task automatic test_release();
        logic exp_oa, exp_fa, exp_ob, exp_fb;
        in_a[2] = 1'b1;
        in_b[2] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (out_a[2] !== 1'b1 || out_b[2] !== 1'b1) begin
            bad++;
            $display("FAIL release_setup: out_a2 %b out_b2 %b want 1 1", out_a[2], out_b[2]);
        end
        in_a[2] = 1'b0;
        in_b[2] = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            @(posedge clk);
            #1;
            exp_oa = (j < 6);
            exp_fa = (j == 6);
            exp_ob = (j < 2);
            exp_fb = (j == 2);
            total++;
            if (out_a[2] !== exp_oa || fall_a[2] !== exp_fa || any_a !== exp_fa) begin
                bad++;
                $display("FAIL release_deb j=%0d: out %b fall %b any %b want %b %b %b",
                         j, out_a[2], fall_a[2], any_a, exp_oa, exp_fa, exp_fa);
            end
            total++;
            if (out_b[2] !== exp_ob || fall_b[2] !== exp_fb || any_b !== exp_fb) begin
                bad++;
                $display("FAIL release_fast j=%0d: out %b fall %b any %b want %b %b %b",
                         j, out_b[2], fall_b[2], any_b, exp_ob, exp_fb, exp_fb);
            end
        end
    endtask

    // Tick edges of dut_c fall at rel_cyc + 4*m.
    task automatic test_prescale();
        logic [3:0] exp_out, exp_rise;
        for (int w = 0; w < 8; w++) begin
            if (((cyc - rel_cyc) % 4) == 0) break;
            @(posedge clk);
            #1;
        end
        in_c = 4'b0001;
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk);
            #1;
            exp_out  = (j >= 12) ? 4'b0001 : 4'b0000;
            exp_rise = (j == 12) ? 4'b0001 : 4'b0000;
            total++;
            if (out_c !== exp_out || rise_c !== exp_rise || fall_c !== 4'b0) begin
                bad++;
                $display("FAIL prescale j=%0d: out %b rise %b fall %b want %b %b 0000",
                         j, out_c, rise_c, fall_c, exp_out, exp_rise);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_out, exp_rise;
        logic       exp_any;
        in_a = 4'b0000;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (out_a !== 4'b0000) begin
            bad++;
            $display("FAIL simul_setup: got %b want 0000", out_a);
        end
        in_a = 4'b1111;
        for (int j = 0; j <= 8; j++) begin
            @(posedge clk);
            #1;
            exp_out  = (j >= 6) ? 4'b1111 : 4'b0000;
            exp_rise = (j == 6) ? 4'b1111 : 4'b0000;
            exp_any  = (j == 6);
            total++;
            if (out_a !== exp_out || rise_a !== exp_rise || any_a !== exp_any || fall_a !== 4'b0) begin
                bad++;
                $display("FAIL simul j=%0d: out %b rise %b any %b fall %b want %b %b %b 0000",
                         j, out_a, rise_a, any_a, fall_a, exp_out, exp_rise, exp_any);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_out, exp_rise;
        in_a = 4'b0010;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (out_a !== 4'b0010) begin
            bad++;
            $display("FAIL midrst_setup: got %b want 0010", out_a);
        end
        in_a = 4'b0011;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_a !== 4'b0 || fall_a !== 4'b0 || rise_a !== 4'b0 || any_a !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear: out %b fall %b rise %b any %b want 0",
                     out_a, fall_a, rise_a, any_a);
        end
        rst = 1'b0;
        rel_cyc = cyc;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk);
            #1;
            exp_out  = (j >= 7) ? 4'b0011 : 4'b0000;
            exp_rise = (j == 7) ? 4'b0011 : 4'b0000;
            total++;
            if (out_a !== exp_out || rise_a !== exp_rise || fall_a !== 4'b0) begin
                bad++;
                $display("FAIL midrst_restart j=%0d: out %b rise %b fall %b want %b %b 0000",
                         j, out_a, rise_a, fall_a, exp_out, exp_rise);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        in_a = 4'b0;
        in_b = 4'b0;
        in_c = 4'b0;
        test_reset();
        test_press();
        test_glitch();
        test_release();
        test_prescale();
        test_simultaneous();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
